// File: rtl/spi_flash_arbiter.sv
// Two-channel arbiter for the shared SPI flash port: round-robin grant,
// minimum chip-deselect gap between grants, and a per-grant watchdog.
module spi_flash_arbiter #(
  parameter int unsigned GAP_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic MCLK,
  input  logic RST,
  input  logic REQ0,
  input  logic REQ1,
  output logic GNT0,
  output logic GNT1,
  input  logic nCS0,
  input  logic MOSI0,
  input  logic CLK0,
  input  logic nCS1,
  input  logic MOSI1,
  input  logic CLK1,
  output logic MISO0,
  output logic MISO1,
  output logic nCS,
  output logic MOSI,
  output logic CLK,
  input  logic MISO,
  output logic BUSY,
  output logic TIMEOUT
);

  localparam logic [CNT_W-1:0] LP_GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_lock0;
  logic             r_lock1;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_busy;
  logic             r_timeout;

  logic w_elig0;
  logic w_elig1;

  assign w_elig0 = REQ0 & ~r_lock0;
  assign w_elig1 = REQ1 & ~r_lock1;

  always_ff @(posedge MCLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_lock0   <= 1'b0;
      r_lock1   <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A timed-out channel is re-armed only once it has dropped its request.
      if (!REQ0) r_lock0 <= 1'b0;
      if (!REQ1) r_lock1 <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_elig0 && (!w_elig1 || r_last)) begin
            r_state <= S_GRANT0;
            r_gnt0  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_elig1) begin
            r_state <= S_GRANT1;
            r_gnt1  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        S_GRANT0: begin
          if (!REQ0) begin
            r_state <= S_GAP;
            r_gnt0  <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == LP_TO_LAST) begin
            r_state   <= S_GAP;
            r_gnt0    <= 1'b0;
            r_last    <= 1'b0;
            r_lock0   <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_GRANT1: begin
          if (!REQ1) begin
            r_state <= S_GAP;
            r_gnt1  <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == LP_TO_LAST) begin
            r_state   <= S_GAP;
            r_gnt1    <= 1'b0;
            r_last    <= 1'b1;
            r_lock1   <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign GNT0    = r_gnt0;
  assign GNT1    = r_gnt1;
  assign BUSY    = r_busy;
  assign TIMEOUT = r_timeout;

  // Pin mux is purely combinational on the registered grant; idle pins are deselected.
  assign nCS   = r_gnt0 ? nCS0  : (r_gnt1 ? nCS1  : 1'b1);
  assign MOSI  = r_gnt0 ? MOSI0 : (r_gnt1 ? MOSI1 : 1'b0);
  assign CLK   = r_gnt0 ? CLK0  : (r_gnt1 ? CLK1  : 1'b0);
  assign MISO0 = r_gnt0 & MISO;
  assign MISO1 = r_gnt1 & MISO;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter: per-cycle vector table
// plus hand-written watchdog and reset-mid-grant sequences.
module tb_spi_flash_arbiter;

  localparam int unsigned GAP_CYCLES     = 3;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned NVEC           = 29;

  logic MCLK, RST, REQ0, REQ1;
  logic GNT0, GNT1;
  logic nCS0, MOSI0, CLK0, nCS1, MOSI1, CLK1;
  logic MISO0, MISO1, nCS, MOSI, CLK, MISO, BUSY, TIMEOUT;

  int checks = 0;
  int errors = 0;

  spi_flash_arbiter #(
    .GAP_CYCLES    (GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (16)
  ) dut (
    .MCLK(MCLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .GNT0(GNT0), .GNT1(GNT1),
    .nCS0(nCS0), .MOSI0(MOSI0), .CLK0(CLK0),
    .nCS1(nCS1), .MOSI1(MOSI1), .CLK1(CLK1),
    .MISO0(MISO0), .MISO1(MISO1),
    .nCS(nCS), .MOSI(MOSI), .CLK(CLK), .MISO(MISO),
    .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Inputs:  rst req0 req1 ncs0 mosi0 clk0 ncs1 mosi1 clk1 miso
  // Outputs: gnt0 gnt1 ncs mosi clk miso0 miso1 busy timeout
  typedef struct packed {
    logic [9:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic logic [8:0] outs();
    return {GNT0, GNT1, nCS, MOSI, CLK, MISO0, MISO1, BUSY, TIMEOUT};
  endfunction

  task automatic drive(input logic [9:0] v);
    {RST, REQ0, REQ1, nCS0, MOSI0, CLK0, nCS1, MOSI1, CLK1, MISO} = v;
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  int gnt_cycles, to_cnt, to_bad;
  logic prev_g;

  initial begin
    // Reset, single ch0 transaction, gap timing
    tbl[0]  = {10'b1001001000, 9'b001000000};
    tbl[1]  = {10'b0101001001, 9'b101001010};
    tbl[2]  = {10'b0100111000, 9'b100110010};
    tbl[3]  = {10'b0100001001, 9'b100001010};
    tbl[4]  = {10'b0101101001, 9'b101101010};
    tbl[5]  = {10'b0001001001, 9'b001000010};
    tbl[6]  = {10'b0001001001, 9'b001000010};
    tbl[7]  = {10'b0001001001, 9'b001000010};
    tbl[8]  = {10'b0001001001, 9'b001000000};
    // Reset, simultaneous request -> ch0, then held REQ1 granted after gap
    tbl[9]  = {10'b1001001000, 9'b001000000};
    tbl[10] = {10'b0111001000, 9'b101000010};
    tbl[11] = {10'b0011001000, 9'b001000010};
    tbl[12] = {10'b0011001000, 9'b001000010};
    tbl[13] = {10'b0011001000, 9'b001000010};
    tbl[14] = {10'b0011001000, 9'b001000000};
    tbl[15] = {10'b0011001111, 9'b011110110};
    // Release ch1; both requests raised during gap -> ch0 wins round-robin
    tbl[16] = {10'b0001001001, 9'b001000010};
    tbl[17] = {10'b0111001001, 9'b001000010};
    tbl[18] = {10'b0111001001, 9'b001000010};
    tbl[19] = {10'b0111001001, 9'b001000000};
    tbl[20] = {10'b0110011001, 9'b100011010};
    // Ch0 drops REQ with nCS0 still low: nCS forced high, gap, then ch1
    tbl[21] = {10'b0010011001, 9'b001000010};
    tbl[22] = {10'b0010011001, 9'b001000010};
    tbl[23] = {10'b0010011001, 9'b001000010};
    tbl[24] = {10'b0010011001, 9'b001000000};
    tbl[25] = {10'b0011000101, 9'b010100110};
    // REQ0 pulse and ch0 line activity during ch1 grant have no effect
    tbl[26] = {10'b0111110010, 9'b010010010};
    tbl[27] = {10'b0011001101, 9'b011100110};
    // Reset mid-grant
    tbl[28] = {10'b1010000111, 9'b001000000};

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].in);
      step();
      check($sformatf("vec%0d", i), int'(outs()), int'(tbl[i].exp));
    end

    // Reset while ch0 is mid-transaction with nCS0 low
    drive(10'b0101001000);
    step();
    drive(10'b0100111001);
    #1;
    check("rst_pre_ncs", int'(nCS), 0);
    drive(10'b1100111001);
    step();
    check("rst_mid_grant", int'(outs()), int'(9'b001000000));

    // Watchdog: REQ1 held, grant must last exactly TIMEOUT_CYCLES
    drive(10'b0001001000);
    REQ1 = 1'b1;
    gnt_cycles = 0;
    to_cnt = 0;
    to_bad = 0;
    prev_g = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (GNT1) gnt_cycles++;
      if (TIMEOUT) begin
        to_cnt++;
        if (!(prev_g && !GNT1)) to_bad++;
      end
      prev_g = GNT1;
    end
    check("to_grant_len", gnt_cycles, int'(TIMEOUT_CYCLES));
    check("to_pulse_cnt", to_cnt, 1);
    check("to_pulse_pos", to_bad, 0);
    check("to_idle_locked", int'({BUSY, GNT1}), 0);

    // Lockout of ch1 does not block ch0
    REQ0 = 1'b1;
    step();
    check("lock_other_gnt0", int'({GNT0, GNT1}), 2);

    // Dropping REQ1 clears lockout; re-request is granted after the gap
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    for (int c = 0; c < int'(GAP_CYCLES) + 1; c++) step();
    check("relock_idle", int'(BUSY), 0);
    REQ1 = 1'b1;
    step();
    check("relock_gnt1", int'({GNT0, GNT1}), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
